// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline stage indices, register constants and hazard cause encoding.
package pipe_pkg;
  localparam int FE_STAGE = 0;
  localparam int DE_STAGE = 1;
  localparam int EX_STAGE_DEF = 2;
  localparam int ME_STAGE = 3;
  localparam int REG_W_DEF = 5;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_EXT, CAUSE_REDIRECT, CAUSE_LOADUSE} cause_e;
endpackage

// File: rtl/pipe_load_scoreboard.sv
// pipe_load_scoreboard: shift register of loads that left EX but cannot yet forward, with per-source match.
module pipe_load_scoreboard
  import pipe_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int REG_W = REG_W_DEF
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             ld_valid,
  input  logic [REG_W-1:0] ld_dst,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  output logic             hit_a,
  output logic             hit_b
);
  logic [DEPTH-1:0] vld;
  logic [REG_W-1:0] dst [DEPTH];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) dst[i] <= '0;
    end else if (shift) begin
      vld[0] <= ld_valid;
      dst[0] <= ld_dst;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        dst[i] <= dst[i-1];
      end
    end
  end
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_a = hit_a | (vld[i] && dst[i] == src_a);
      hit_b = hit_b | (vld[i] && dst[i] == src_b);
    end
  end
endmodule

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: per-stage stall/flush controller for external holds, EX redirects and multi-cycle load-use.
// Define PIPE_HAZARD_CTL_PERF_EN to build the saturating perf counters; otherwise they read as zero.
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int EX_STAGE   = EX_STAGE_DEF,
  parameter int LOAD_LAT   = 1,
  parameter int REG_W      = REG_W_DEF
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] ext_stall,
  input  logic                  redirect_ex,
  input  logic                  ex_valid,
  input  logic                  ex_is_load,
  input  logic [REG_W-1:0]      ex_dst,
  input  logic                  dec_valid,
  input  logic [REG_W-1:0]      dec_rs,
  input  logic [REG_W-1:0]      dec_rt,
  input  logic                  dec_rs_use,
  input  logic                  dec_rt_use,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  load_use,
  output logic [31:0]           perf_stall_cyc,
  output logic [31:0]           perf_flush_evt,
  output logic [31:0]           perf_lu_evt
);
  localparam logic [NUM_STAGES-1:0] REDIR_MASK = NUM_STAGES'((1 << (EX_STAGE + 1)) - 2);
  localparam logic [NUM_STAGES-1:0] LU_STALL = NUM_STAGES'((1 << (DE_STAGE + 1)) - 1);
  localparam logic [NUM_STAGES-1:0] LU_FLUSH = NUM_STAGES'(1 << (DE_STAGE + 1));
  logic [NUM_STAGES-1:0] stall_ext, flush_ext, stall_raw, flush_raw;
  logic ex_ld, redirect_take, chk_a, chk_b, sb_a, sb_b, hazard;
  cause_e cause;
  assign ex_ld = ex_valid && ex_is_load;
  // Everything at or below the oldest requester holds; the stage just past it gets a bubble.
  always_comb begin
    stall_ext = '0;
    flush_ext = '0;
    for (int k = 0; k < NUM_STAGES; k++) stall_ext[k] = |(ext_stall >> k);
    for (int k = 1; k < NUM_STAGES; k++) flush_ext[k] = ext_stall[k-1] && !stall_ext[k];
  end
  assign redirect_take = redirect_ex && !stall_ext[EX_STAGE];
  assign chk_a = dec_valid && dec_rs_use && dec_rs != REG_W'(REG_ZERO);
  assign chk_b = dec_valid && dec_rt_use && dec_rt != REG_W'(REG_ZERO);
  assign hazard = (chk_a && ((ex_ld && ex_dst == dec_rs) || sb_a)) ||
                  (chk_b && ((ex_ld && ex_dst == dec_rt) || sb_b));
  // Decode is owned by the first applicable cause: older holds, then a taken redirect, then load-use.
  assign cause = !reset                ? CAUSE_NONE :
                 stall_ext[DE_STAGE]   ? CAUSE_EXT :
                 redirect_take         ? CAUSE_REDIRECT :
                 hazard                ? CAUSE_LOADUSE : CAUSE_NONE;
  assign load_use = cause == CAUSE_LOADUSE;
  assign stall_raw = stall_ext | (load_use ? LU_STALL : '0);
  assign flush_raw = flush_ext | (redirect_take ? REDIR_MASK : '0) | (load_use ? LU_FLUSH : '0);
  assign flush = reset ? flush_raw : '1;
  assign stall = reset ? stall_raw & ~flush_raw : '0;
  if (LOAD_LAT > 1) begin : g_sb
    pipe_load_scoreboard #(.DEPTH(LOAD_LAT - 1), .REG_W(REG_W)) u_sb (
      .clk(clk),
      .reset(reset),
      .shift(!stall_ext[EX_STAGE]),
      .ld_valid(ex_ld && ex_dst != REG_W'(REG_ZERO)),
      .ld_dst(ex_dst),
      .src_a(dec_rs),
      .src_b(dec_rt),
      .hit_a(sb_a),
      .hit_b(sb_b)
    );
  end else begin : g_nosb
    assign sb_a = 1'b0;
    assign sb_b = 1'b0;
  end
`ifdef PIPE_HAZARD_CTL_PERF_EN
  logic lu_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lu_q <= 1'b0;
      perf_stall_cyc <= '0;
      perf_flush_evt <= '0;
      perf_lu_evt <= '0;
    end else begin
      lu_q <= load_use;
      if (stall[FE_STAGE] && ~&perf_stall_cyc) perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (redirect_take && ~&perf_flush_evt) perf_flush_evt <= perf_flush_evt + 32'd1;
      if (load_use && !lu_q && ~&perf_lu_evt) perf_lu_evt <= perf_lu_evt + 32'd1;
    end
  end
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign perf_stall_cyc = '0;
  assign perf_flush_evt = '0;
  assign perf_lu_evt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb_pipe_hazard_ctl: table vectors plus multi-cycle sequences against LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_pipe_hazard_ctl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] ext_stall, ex_dst, dec_rs, dec_rt;
  logic redirect_ex, ex_valid, ex_is_load, dec_valid, dec_rs_use, dec_rt_use;
  logic [4:0] st1, fl1, st3, fl3;
  logic lu1, lu3;
  logic [31:0] ps1, pf1, pl1, ps3, pf3, pl3;
  logic [31:0] pl3_0, ps3_0, pl1_0, pf3_0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctl #(.LOAD_LAT(1)) d1 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .redirect_ex(redirect_ex),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst(ex_dst), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rs_use(dec_rs_use), .dec_rt_use(dec_rt_use),
    .stall(st1), .flush(fl1), .load_use(lu1),
    .perf_stall_cyc(ps1), .perf_flush_evt(pf1), .perf_lu_evt(pl1)
  );
  pipe_hazard_ctl #(.LOAD_LAT(3)) d3 (
    .clk(clk), .reset(reset), .ext_stall(ext_stall), .redirect_ex(redirect_ex),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_dst(ex_dst), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rs_use(dec_rs_use), .dec_rt_use(dec_rt_use),
    .stall(st3), .flush(fl3), .load_use(lu3),
    .perf_stall_cyc(ps3), .perf_flush_evt(pf3), .perf_lu_evt(pl3)
  );
  typedef struct {
    logic [4:0] es; logic rd, exv, exl; logic [4:0] exd;
    logic dv; logic [4:0] rs, rt; logic rsu, rtu;
    logic [4:0] xs, xf; logic xl;
  } vec_t;
  typedef struct {
    string n; bit c1, c3; logic [4:0] s, f; logic l;
  } exp_t;
  exp_t q[$];
  // es rd exv exl exd | dv rs rt rsu rtu | stall flush load_use
  vec_t vecs[17] = '{
    '{0,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0,  0},
    '{0,  0, 1, 1, 5,  1, 5, 1, 1, 1,  3,  4,  1},
    '{0,  0, 1, 1, 5,  1, 1, 5, 1, 1,  3,  4,  1},
    '{0,  0, 1, 1, 5,  1, 5, 1, 0, 1,  0,  0,  0},
    '{0,  0, 1, 1, 5,  0, 5, 5, 1, 1,  0,  0,  0},
    '{0,  0, 1, 0, 5,  1, 5, 5, 1, 1,  0,  0,  0},
    '{0,  0, 1, 1, 0,  1, 0, 0, 1, 1,  0,  0,  0},
    '{1,  0, 0, 0, 0,  0, 0, 0, 0, 0,  1,  2,  0},
    '{0,  1, 1, 1, 5,  1, 5, 0, 1, 0,  0,  6,  0},
    '{8,  1, 0, 0, 0,  0, 0, 0, 0, 0, 15, 16,  0},
    '{4,  0, 0, 0, 0,  0, 0, 0, 0, 0,  7,  8,  0},
    '{16, 0, 1, 1, 5,  1, 5, 0, 1, 0, 31,  0,  0},
    '{2,  1, 0, 0, 0,  0, 0, 0, 0, 0,  1,  6,  0},
    '{0,  1, 0, 0, 0,  0, 0, 0, 0, 0,  0,  6,  0},
    '{1,  1, 0, 0, 0,  0, 0, 0, 0, 0,  1,  6,  0},
    '{0,  0, 0, 1, 5,  1, 5, 5, 1, 1,  0,  0,  0},
    '{1,  0, 1, 1, 5,  1, 5, 0, 1, 0,  1,  6,  1}
  };
  task automatic cmp(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", n, act, exp);
    end
  endtask
  task automatic expect_out(input string n, input bit c1, input bit c3, input logic [4:0] s,
                            input logic [4:0] f, input logic l);
    exp_t e;
    e.n = n; e.c1 = c1; e.c3 = c3; e.s = s; e.f = f; e.l = l;
    q.push_back(e);
  endtask
  task automatic check_out();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.c1) begin
        cmp({e.n, " L1 stall"}, 32'(st1), 32'(e.s));
        cmp({e.n, " L1 flush"}, 32'(fl1), 32'(e.f));
        cmp({e.n, " L1 load_use"}, 32'(lu1), 32'(e.l));
      end
      if (e.c3) begin
        cmp({e.n, " L3 stall"}, 32'(st3), 32'(e.s));
        cmp({e.n, " L3 flush"}, 32'(fl3), 32'(e.f));
        cmp({e.n, " L3 load_use"}, 32'(lu3), 32'(e.l));
      end
    end
  endtask
  task automatic idle();
    ext_stall = 0; redirect_ex = 0; ex_valid = 0; ex_is_load = 0; ex_dst = 0;
    dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_rs_use = 0; dec_rt_use = 0;
  endtask
  task automatic drive(input vec_t v);
    ext_stall = v.es; redirect_ex = v.rd; ex_valid = v.exv; ex_is_load = v.exl; ex_dst = v.exd;
    dec_valid = v.dv; dec_rs = v.rs; dec_rt = v.rt; dec_rs_use = v.rsu; dec_rt_use = v.rtu;
  endtask
  initial begin
    idle();
    expect_out("reset", 1, 1, 5'b00000, 5'b11111, 0);
    check_out();
    cmp("perf at reset", ps1 | pf1 | pl1 | ps3 | pf3 | pl3, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      idle();
      repeat (2) @(negedge clk);
      drive(vecs[i]);
      expect_out($sformatf("vec%0d", i), 1, 1, vecs[i].xs, vecs[i].xf, vecs[i].xl);
      check_out();
      @(negedge clk);
    end
    // LOAD_LAT=1: single-cycle stall; the LOAD_LAT=3 copy still sees the load in its scoreboard
    idle();
    repeat (2) @(negedge clk);
    ex_valid = 1; ex_is_load = 1; ex_dst = 5; dec_valid = 1; dec_rs = 5; dec_rs_use = 1; dec_rt = 1; dec_rt_use = 1;
    expect_out("lu1 c0", 1, 1, 5'b00011, 5'b00100, 1);
    check_out();
    @(negedge clk);
    ex_valid = 0;
    expect_out("lu1 c1", 1, 0, 0, 0, 0);
    expect_out("lu1 c1 sb", 0, 1, 5'b00011, 5'b00100, 1);
    check_out();
    // LOAD_LAT=3: dependent arrives one cycle after the load left EX -> two stall cycles
    idle();
    repeat (2) @(negedge clk);
    pl3_0 = pl3; ps3_0 = ps3; pl1_0 = pl1;
    ex_valid = 1; ex_is_load = 1; ex_dst = 7;
    expect_out("lu3 c0", 1, 1, 0, 0, 0);
    check_out();
    @(negedge clk);
    ex_valid = 0; dec_valid = 1; dec_rs = 7; dec_rs_use = 1;
    expect_out("lu3 c1", 0, 1, 5'b00011, 5'b00100, 1);
    expect_out("lu3 c1 L1", 1, 0, 0, 0, 0);
    check_out();
    @(negedge clk);
    expect_out("lu3 c2", 0, 1, 5'b00011, 5'b00100, 1);
    check_out();
    @(negedge clk);
    expect_out("lu3 c3", 1, 1, 0, 0, 0);
    check_out();
`ifdef PIPE_HAZARD_CTL_PERF_EN
    cmp("perf_lu_evt delta", pl3 - pl3_0, 1);
    cmp("perf_stall_cyc delta", ps3 - ps3_0, 2);
    cmp("L1 perf_lu_evt delta", pl1 - pl1_0, 0);
`else
    cmp("perf tied off", ps3 | pf3 | pl3 | pl1, 0);
`endif
    // ext hold at ME defers the redirect until the hold drops
    idle();
    repeat (2) @(negedge clk);
    pf3_0 = pf3;
    ext_stall = 5'b01000; redirect_ex = 1;
    expect_out("ext+redir c0", 1, 1, 5'b01111, 5'b10000, 0);
    check_out();
    @(negedge clk);
    ext_stall = 0;
    expect_out("ext+redir c1", 1, 1, 5'b00000, 5'b00110, 0);
    check_out();
    @(negedge clk);
    redirect_ex = 0;
`ifdef PIPE_HAZARD_CTL_PERF_EN
    cmp("perf_flush_evt delta", pf3 - pf3_0, 1);
`else
    cmp("perf_flush_evt off", pf3, 0);
`endif
    // scoreboard must not capture the EX load while EX is held
    idle();
    repeat (2) @(negedge clk);
    ext_stall = 5'b00100; ex_valid = 1; ex_is_load = 1; ex_dst = 9;
    expect_out("hold c0", 1, 1, 5'b00111, 5'b01000, 0);
    check_out();
    @(negedge clk);
    ext_stall = 0; ex_valid = 0; dec_valid = 1; dec_rs = 9; dec_rs_use = 1;
    expect_out("hold c1", 1, 1, 0, 0, 0);
    check_out();
    // reset mid-run with a pending load clears the scoreboard
    idle();
    repeat (2) @(negedge clk);
    ex_valid = 1; ex_is_load = 1; ex_dst = 7;
    @(negedge clk);
    ex_valid = 0; dec_valid = 1; dec_rs = 7; dec_rs_use = 1;
    expect_out("pre reset", 0, 1, 5'b00011, 5'b00100, 1);
    check_out();
    reset = 1'b0;
    expect_out("mid reset", 1, 1, 5'b00000, 5'b11111, 0);
    check_out();
    cmp("perf cleared", ps3 | pf3 | pl3, 0);
    @(negedge clk);
    reset = 1'b1;
    expect_out("post reset", 1, 1, 0, 0, 0);
    check_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctl.md
Name: pipe_hazard_ctl

Overview:
- Parametrised stall/flush controller for the in-order pipeline.
- Replaces the fixed lw-stall/branch-flush glue in the core top.
- Generalises to NUM_STAGES stages, multi-cycle load-to-use latency (pending-load scoreboard) and per-stage external stall requests.
- Drives one stall bit and one flush bit per pipeline register; stage 0 = fetch, 1 = decode, EX_STAGE = execute.

Parameters:
NUM_STAGES, 5, pipeline registers controlled; legal 4..8
EX_STAGE, 2, index of the execute stage (the branch-resolve stage); legal 2..NUM_STAGES-2
LOAD_LAT, 1, cycles after a load leaves EX before its data can be forwarded; legal 1..4
REG_W, 5, register-specifier width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ext_stall  in  NUM_STAGES  stage k requests a hold (e.g. cache miss)
redirect_ex  in  1  taken branch/jump resolved in EX_STAGE
ex_valid  in  1  valid instruction in EX_STAGE
ex_is_load  in  1  EX instruction is a load
ex_dst  in  REG_W  EX destination register
dec_valid  in  1  valid instruction in decode
dec_rs, dec_rt  in  REG_W  decode source specifiers
dec_rs_use, dec_rt_use  in  1  source actually read
stall  out  NUM_STAGES  hold pipeline register k
flush  out  NUM_STAGES  clear pipeline register k (insert bubble) on next edge
load_use  out  1  current cycle is a load-use stall
perf_stall_cyc, perf_flush_evt, perf_lu_evt  out  32 each  perf counters (see Optional Feature)

Behaviour:
- All outputs are combinational from inputs plus internal state.
- While reset is low:
  - flush = all ones, stall = 0, load_use = 0.
  - Scoreboard and counters cleared asynchronously.
- External stall:
  - Let h = highest k with ext_stall[k]=1.
  - stall[0..h] = 1; flush[h+1] = 1 if h+1 < NUM_STAGES.
  - Older requests dominate all other causes.
- Redirect:
  - If redirect_ex=1 and stall[EX_STAGE]=0: flush[1..EX_STAGE] = 1 (kills the wrong-path instructions in FE and DE).
  - While stall[EX_STAGE]=1 the redirect is ignored; EX reasserts it on the cycle it advances.
- Scoreboard:
  - LOAD_LAT-1 entries {valid, dst}; entry 0 is youngest.
  - On an edge where stall[EX_STAGE]=0, the scoreboard shifts by one and entry 0 loads {ex_valid & ex_is_load & (ex_dst≠0), ex_dst}.
  - On an edge with stall[EX_STAGE]=1, the scoreboard holds.
  - LOAD_LAT=1 means no storage; only the EX instruction is checked.
- Load-use hazard:
  - A source is checked when dec_valid & use & (src≠0).
  - It matches the EX load (ex_valid & ex_is_load & ex_dst==src) or any valid scoreboard entry with dst==src.
  - Action: stall[0..1] = 1, flush[2] = 1, load_use = 1.
  - Only applied if no external stall at k ≥ 1 and no redirect is taken this cycle.
  - Redirect wins over load-use because the dependent instruction is flushed.
- Register 0 never hazards.
- Simultaneous ext_stall[k≥EX_STAGE] and redirect_ex: only stall/flush from ext_stall; redirect deferred.
- Simultaneous ext_stall[0] and redirect: redirect flush still applies to stages 1..EX_STAGE; stall[0] stays asserted.
- A stage never has stall and flush both set except flush overriding stall on reset; if both would be set, flush wins.

Optional Feature:
- Macro PIPE_HAZARD_CTL_PERF_EN.
- Defined:
  - Three 32-bit saturating counters, cleared by reset.
  - perf_stall_cyc counts cycles with stall[0]=1.
  - perf_flush_evt counts cycles with redirect flush applied.
  - perf_lu_evt counts rising edges of load_use (a multi-cycle stall counts once).
- Not defined: perf outputs tied to 0 and no counter flops.

Decomposition:
- Shared pipe_pkg holds:
  - stage index constants FE_STAGE=0, DE_STAGE=1, EX_STAGE_DEF=2, ME_STAGE=3.
  - REG_W_DEF=5 and REG_ZERO=0.
  - A 2-bit stall-cause enum {CAUSE_NONE, CAUSE_EXT, CAUSE_REDIRECT, CAUSE_LOADUSE}.
- One sub-module, pipe_load_scoreboard: the LOAD_LAT-1 shift register plus match logic, returning a per-source hit.

Test Plan:
1. Reset low mid-run with scoreboard loaded → flush=5'b11111 immediately, stall=0; after release, no load_use for a previously pending dst.
2. LOAD_LAT=1: EX lw r5; decode add r6,r5,r1 → one cycle stall=5'b00011, flush=5'b00100, load_use=1; next cycle clear.
3. LOAD_LAT=3: lw r7 leaves EX, dependent reaches decode one cycle later → stall held exactly 2 cycles, perf_lu_evt +1 (with PIPE_HAZARD_CTL_PERF_EN).
4. redirect_ex=1 with simultaneous load-use on r5 → flush=5'b00110, stall=0, load_use=0.
5. ext_stall=5'b01000 with redirect_ex=1 → stall=5'b01111, flush=5'b10000; redirect flush appears on the first cycle after ext_stall drops.
6. Decode reads r0 while EX is lw r0 → no stall; ext_stall[0]=1 alone → stall=5'b00001, flush=5'b00010.
